// File: rtl/reg_pkg.sv
// Shared datapath constants: default widths and the register reset value.
package reg_pkg;

    localparam int unsigned DefaultDw = 8;
    localparam int unsigned DefaultAw = 2;
    localparam int unsigned RegRstVal = 0;

endpackage

// File: rtl/reg_bank_if.sv
// Register-bank port bundle: write-back, issue, two read ports and scoreboard status.
interface reg_bank_if
    import reg_pkg::*;
#(
    parameter int unsigned DW = DefaultDw,
    parameter int unsigned AW = DefaultAw
) ();

    localparam int unsigned NREG = 2 ** AW;

    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   i;
    logic [AW-1:0]   sr;
    logic [AW-1:0]   dr;
    logic [DW-1:0]   s;
    logic [DW-1:0]   d;
    logic            iss;
    logic [AW-1:0]   iss_a;
    logic [NREG-1:0] busy;
    logic            hazard;
    logic            stray;

    modport master (
        output we, wa, i, sr, dr, iss, iss_a,
        input  s, d, busy, hazard, stray
    );

    modport slave (
        input  we, wa, i, sr, dr, iss, iss_a,
        output s, d, busy, hazard, stray
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write tracker: one busy bit per register plus a sticky stray-write flag.
// When ZERO_R0 is set, r0 can never be reserved and never raises stray.
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int unsigned AW      = DefaultAw,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic              iss_i,
    input  logic [AW-1:0]     iss_a_i,
    output logic [2**AW-1:0]  busy_o,
    output logic              stray_o
);

    localparam int unsigned NREG = 2 ** AW;

    logic [NREG-1:0] busy_q, busy_d;
    logic            stray_q, stray_d;
    logic            wb_ok, iss_ok;

    // Next busy/stray: write-back clears, issue sets afterwards so a same-address issue wins
    always_comb begin
        wb_ok   = we_i && !(ZERO_R0 && wa_i == '0);
        iss_ok  = iss_i && !(ZERO_R0 && iss_a_i == '0);
        busy_d  = busy_q;
        stray_d = stray_q;
        if (wb_ok) begin
            if (!busy_q[wa_i]) begin
                stray_d = 1'b1;
            end
            busy_d[wa_i] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_a_i] = 1'b1;
        end
    end

    // Tracker state, cleared asynchronously so in-flight reservations are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            stray_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            stray_q <= stray_d;
        end
    end

    // Expose tracker state
    always_comb begin
        busy_o  = busy_q;
        stray_o = stray_q;
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank with two combinational read ports, one write-back port and a
// pending-write scoreboard. Optional macro REG_BANK_BYPASS_EN forwards the
// write-back data to a read port addressing the register being written.
module reg_bank
    import reg_pkg::*;
#(
    parameter int unsigned DW      = DefaultDw,
    parameter int unsigned AW      = DefaultAw,
    parameter bit          ZERO_R0 = 1'b0
) (
    input logic       clk,
    input logic       rst,
    reg_bank_if.slave bus
);

    localparam int unsigned NREG = 2 ** AW;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic            wr_ok;
    logic            byp_s, byp_d;
    logic [NREG-1:0] busy;
    logic            stray;

    // Write-back qualifier: r0 is hardwired when ZERO_R0 is set
    always_comb begin
        wr_ok = bus.we && !(ZERO_R0 && bus.wa == '0);
    end

    // Next register contents
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[bus.wa] = bus.i;
        end
    end

    // Data array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NREG; k++) begin
                regs_q[k] <= DW'(RegRstVal);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    // Forward same-cycle write-back data; wr_ok already excludes a locked r0
    always_comb begin
        byp_s = wr_ok && !rst && (bus.wa == bus.sr);
        byp_d = wr_ok && !rst && (bus.wa == bus.dr);
    end
`else
    // No forwarding: new data is visible only after the write edge
    always_comb begin
        byp_s = 1'b0;
        byp_d = 1'b0;
    end
`endif

    // Read muxes, hazard and status outputs
    always_comb begin
        bus.s = byp_s ? bus.i : regs_q[bus.sr];
        bus.d = byp_d ? bus.i : regs_q[bus.dr];
        if (ZERO_R0 && bus.sr == '0) begin
            bus.s = '0;
        end
        if (ZERO_R0 && bus.dr == '0) begin
            bus.d = '0;
        end
        // A forwarded operand is already available, so it cannot stall
        bus.hazard = (busy[bus.sr] && !byp_s) || (busy[bus.dr] && !byp_d);
        bus.busy   = busy;
        bus.stray  = stray;
    end

    reg_scoreboard #(
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bus.we),
        .wa_i    (bus.wa),
        .iss_i   (bus.iss),
        .iss_a_i (bus.iss_a),
        .busy_o  (busy),
        .stray_o (stray)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: two instances (ZERO_R0 = 0 and 1) share one stimulus
// stream; expected outputs come from an array-based model and are queued for
// a negedge monitor.
module tb_reg_bank;
    import reg_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

`ifdef REG_BANK_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       we, iss;
    logic [1:0] wa, sr, dr, iss_a;
    logic [7:0] i_dat;

    reg_bank_if #(.DW(DW), .AW(AW)) bus0 ();
    reg_bank_if #(.DW(DW), .AW(AW)) bus1 ();

    assign bus0.we = we;    assign bus1.we = we;
    assign bus0.wa = wa;    assign bus1.wa = wa;
    assign bus0.i = i_dat;  assign bus1.i = i_dat;
    assign bus0.sr = sr;    assign bus1.sr = sr;
    assign bus0.dr = dr;    assign bus1.dr = dr;
    assign bus0.iss = iss;  assign bus1.iss = iss;
    assign bus0.iss_a = iss_a;
    assign bus1.iss_a = iss_a;

    reg_bank #(.DW(DW), .AW(AW), .ZERO_R0(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    reg_bank #(.DW(DW), .AW(AW), .ZERO_R0(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model: index 0 is the plain bank, index 1 has r0 hardwired
    logic [7:0] m_reg [2][4];
    bit         m_busy [2][4];
    bit         m_stray [2];

    typedef struct {
        string           tag;
        logic [1:0][7:0] s;
        logic [1:0][7:0] d;
        logic [1:0][3:0] busy;
        logic [1:0]      hz;
        logic [1:0]      st;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    function automatic bit locked(int z, logic [1:0] a);
        return (z == 1) && (a == 2'd0);
    endfunction

    function automatic bit bypassed(int z, logic [1:0] a);
        return Byp && !rst && we && (wa == a) && !locked(z, a);
    endfunction

    function automatic logic [7:0] m_read(int z, logic [1:0] a);
        if (locked(z, a)) return 8'h00;
        if (bypassed(z, a)) return i_dat;
        return m_reg[z][a];
    endfunction

    task automatic model_clear();
        for (int z = 0; z < 2; z++) begin
            m_stray[z] = 1'b0;
            for (int a = 0; a < 4; a++) begin
                m_reg[z][a]  = 8'h00;
                m_busy[z][a] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (we && !locked(z, wa)) begin
                    if (!m_busy[z][wa]) m_stray[z] = 1'b1;
                    m_reg[z][wa]  = i_dat;
                    m_busy[z][wa] = 1'b0;
                end
                if (iss && !locked(z, iss_a)) m_busy[z][iss_a] = 1'b1;
            end
        end
    endtask

    task automatic push_expect(string tag);
        exp_t e;
        e.tag = tag;
        for (int z = 0; z < 2; z++) begin
            e.s[z] = m_read(z, sr);
            e.d[z] = m_read(z, dr);
            for (int a = 0; a < 4; a++) e.busy[z][a] = m_busy[z][a];
            e.hz[z] = (m_busy[z][sr] && !bypassed(z, sr)) || (m_busy[z][dr] && !bypassed(z, dr));
            e.st[z] = m_stray[z];
        end
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus; entered and left 1 time unit after posedge
    task automatic cyc(string tag, bit r, bit w, logic [1:0] a, logic [7:0] dat,
                       logic [1:0] s_a, logic [1:0] d_a, bit is, logic [1:0] ia);
        rst = r; we = w; wa = a; i_dat = dat; sr = s_a; dr = d_a; iss = is; iss_a = ia;
        if (r) model_clear();
        push_expect(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset raised and dropped between two rising edges
    task automatic rst_pulse(string tag);
        rst = 1'b1; we = 1'b0; iss = 1'b0;
        model_clear();
        push_expect(tag);
        #6;
        rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(string tag, string field, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s: got %0h required %0h", tag, field, got, want);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "dut0.s", 32'(bus0.s), 32'(e.s[0]));
            chk(e.tag, "dut0.d", 32'(bus0.d), 32'(e.d[0]));
            chk(e.tag, "dut0.busy", 32'(bus0.busy), 32'(e.busy[0]));
            chk(e.tag, "dut0.hazard", 32'(bus0.hazard), 32'(e.hz[0]));
            chk(e.tag, "dut0.stray", 32'(bus0.stray), 32'(e.st[0]));
            chk(e.tag, "dut1.s", 32'(bus1.s), 32'(e.s[1]));
            chk(e.tag, "dut1.d", 32'(bus1.d), 32'(e.d[1]));
            chk(e.tag, "dut1.busy", 32'(bus1.busy), 32'(e.busy[1]));
            chk(e.tag, "dut1.hazard", 32'(bus1.hazard), 32'(e.hz[1]));
            chk(e.tag, "dut1.stray", 32'(bus1.stray), 32'(e.st[1]));
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; i_dat = '0; sr = '0; dr = '0; iss = 1'b0; iss_a = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Reset held across edges with we/iss active: nothing lands
        cyc("rst_hold", 1, 1, 2'd2, 8'h11, 2'd2, 2'd3, 1, 2'd2);
        cyc("rst_hold2", 1, 1, 2'd3, 8'h22, 2'd3, 2'd3, 1, 2'd3);
        cyc("out_of_rst", 0, 0, 2'd0, 8'h00, 2'd2, 2'd3, 0, 2'd0);

        // Reserve r2, write it back two cycles later
        cyc("iss2", 0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 1, 2'd2);
        cyc("busy2", 0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 0, 2'd0);
        cyc("wb2", 0, 1, 2'd2, 8'hAA, 2'd2, 2'd2, 0, 2'd0);
        cyc("rd2", 0, 0, 2'd0, 8'h00, 2'd2, 2'd0, 0, 2'd0);

        // Hazard on r1 until its write-back
        cyc("iss1", 0, 0, 2'd0, 8'h00, 2'd1, 2'd3, 1, 2'd1);
        cyc("haz1", 0, 0, 2'd0, 8'h00, 2'd1, 2'd3, 0, 2'd0);
        cyc("wb1", 0, 1, 2'd1, 8'h5A, 2'd1, 2'd3, 0, 2'd0);
        cyc("nohaz1", 0, 0, 2'd0, 8'h00, 2'd1, 2'd3, 0, 2'd0);
        cyc("haz_same", 0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 1, 2'd2);
        cyc("haz_same2", 0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 0, 2'd0);
        cyc("wb2b", 0, 1, 2'd2, 8'h9D, 2'd2, 2'd2, 0, 2'd0);

        // Write-back to a non-busy register raises sticky stray
        cyc("stray_wr", 0, 1, 2'd1, 8'hC3, 2'd1, 2'd1, 0, 2'd0);
        cyc("stray_hold", 0, 0, 2'd0, 8'h00, 2'd1, 2'd2, 0, 2'd0);
        cyc("stray_hold2", 0, 0, 2'd0, 8'h00, 2'd3, 2'd1, 0, 2'd0);

        // Issue and write-back to r3 in the same cycle
        cyc("iss_we3", 0, 1, 2'd3, 8'h3C, 2'd3, 2'd0, 1, 2'd3);
        cyc("rd3", 0, 0, 2'd0, 8'h00, 2'd3, 2'd1, 0, 2'd0);

        // Write-back to a busy register (bypass case when enabled)
        cyc("iss2c", 0, 0, 2'd0, 8'h00, 2'd2, 2'd1, 1, 2'd2);
        cyc("byp2", 0, 1, 2'd2, 8'h55, 2'd2, 2'd1, 0, 2'd0);
        cyc("rd2c", 0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 0, 2'd0);

        // r0 handling
        cyc("r0_ff", 0, 1, 2'd0, 8'hFF, 2'd0, 2'd0, 0, 2'd0);
        cyc("rd_r0", 0, 0, 2'd0, 8'h00, 2'd0, 2'd2, 0, 2'd0);
        cyc("iss_r0", 0, 0, 2'd0, 8'h00, 2'd0, 2'd0, 1, 2'd0);
        cyc("busy_r0", 0, 0, 2'd0, 8'h00, 2'd0, 2'd3, 0, 2'd0);

        // Asynchronous reset pulse without a clock edge
        rst_pulse("rst_async");
        cyc("post_rst", 0, 0, 2'd0, 8'h00, 2'd2, 2'd3, 0, 2'd0);

        // Reservation in flight when reset asserts is discarded
        cyc("iss1b", 0, 0, 2'd0, 8'h00, 2'd1, 2'd3, 1, 2'd1);
        cyc("rst_iss", 1, 1, 2'd2, 8'h77, 2'd1, 2'd2, 1, 2'd3);
        cyc("post_rst2", 0, 0, 2'd0, 8'h00, 2'd3, 2'd1, 0, 2'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst_pulse("rnd_rst_pulse");
            end else begin
                cyc("rnd", ($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 8'($urandom), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)));
            end
        end

        // Let the monitor consume the last expectation
        we = 1'b0; iss = 1'b0;
        @(negedge clk);
        #1;
        chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width in bits.
REQ-002 SHALL have parameter AW, default 2, meaning address width; register count NREG = 2**AW.
REQ-003 SHALL have parameter ZERO_R0, default 0, meaning 1 makes r0 read-only and always 0.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, meaning clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port we, input, 1, meaning write-back strobe.
REQ-008 SHALL have port wa, input, AW, meaning write-back address.
REQ-009 SHALL have port i, input, DW, meaning write-back data.
REQ-010 SHALL have port sr, input, AW, meaning source read address.
REQ-011 SHALL have port dr, input, AW, meaning destination read address.
REQ-012 SHALL have port s, output, DW, meaning source read data.
REQ-013 SHALL have port d, output, DW, meaning destination read data.
REQ-014 SHALL have port iss, input, 1, meaning issue strobe that reserves register iss_a.
REQ-015 SHALL have port iss_a, input, AW, meaning issue address.
REQ-016 SHALL have port busy, output, NREG, meaning per-register pending-write bit.
REQ-017 SHALL have port hazard, output, 1, meaning busy[sr] OR busy[dr].
REQ-018 SHALL have port stray, output, 1, meaning sticky flag for a write-back to a non-busy register.

Function
REQ-019 SHALL drive s and d combinationally from the register selected by sr and dr, with zero added latency.
REQ-020 SHALL load i into register wa on the rising edge when we=1; one write per cycle.
REQ-021 SHALL set busy[iss_a] on the rising edge when iss=1.
REQ-022 SHALL clear busy[wa] on the rising edge when we=1.
REQ-023 SHALL leave busy[x]=1 after the edge when iss and we hit the same address x in the same cycle: the write lands and the new reservation wins.
REQ-024 SHALL treat iss to an already-busy register as a no-op for busy; busy stays 1.
REQ-025 SHALL set stray on the rising edge when we=1 and busy[wa]=0; the data write still occurs and stray holds until reset.
REQ-026 SHALL, with ZERO_R0=1, ignore writes to r0, keep busy[0]=0, ignore iss to r0, never set stray for wa=0, and read r0 as 0.
REQ-027 SHALL compute hazard combinationally from the current busy vector and sr/dr, including when sr=dr.

Reset
REQ-028 SHALL, while rst=1, force all registers to 0, busy to 0 and stray to 0 immediately, without waiting for a clock edge.
REQ-029 SHALL give reset priority over we and iss in the same cycle; a reservation in flight when reset asserts is discarded.
REQ-030 SHALL, out of reset, drive s=0, d=0, busy=0, hazard=0 and stray=0.

Configuration
REQ-031 SHALL, with macro REG_BANK_BYPASS_EN defined and we=1, drive s=i when wa=sr and d=i when wa=dr (same cycle), and exclude that address from hazard.
REQ-032 SHALL, without REG_BANK_BYPASS_EN, show new data on s and d only after the write edge, and compute hazard from busy alone.
REQ-033 SHALL never bypass r0 when ZERO_R0=1, whether or not REG_BANK_BYPASS_EN is defined.

Structure
REQ-034 SHALL take default DW and AW values and the reset-value constant from the shared package reg_pkg, which other datapath blocks also use.
REQ-035 SHALL implement the busy/stray tracking as sub-module reg_scoreboard, with the data array and read muxes kept in reg_bank.

Verification
REQ-036 SHALL have a bench case: rst pulse mid-cycle with no clk edge -> s=d=0, busy=0 and stray=0 immediately.
REQ-037 SHALL have a bench case: iss with iss_a=2, then we with wa=2, i=8'hAA two cycles later -> busy[2] goes 1 then 0, and sr=2 reads 8'hAA after the write edge.
REQ-038 SHALL have a bench case: busy[1]=1 and sr=1, dr=3 -> hazard=1; after the write-back to r1, hazard=0.
REQ-039 SHALL have a bench case: iss and we both at address 3 in the same cycle -> r3 updated and busy[3]=1.
REQ-040 SHALL have a bench case: we with wa=1 while busy[1]=0 -> r1 written and stray=1, held until rst.
REQ-041 SHALL have a bench case: with REG_BANK_BYPASS_EN, we=1, wa=sr=2, i=8'h55 -> s=8'h55 in the same cycle, and hazard=0 for sr; with ZERO_R0=1, a write of 8'hFF to r0 -> r0 still reads 0.
